// File: rtl/pcileech_rstbtn_ctl_if.sv
// Button pads in, board-level reset/reload/LED/tick nets out.
// master = whoever drives the buttons, slave = the reset/button controller.
interface pcileech_rstbtn_ctl_if;
    logic        user_sw1_n;
    logic        user_sw2_n;
    logic        rst_sys;
    logic        rst_cfg_reload;
    logic        led_pwronblink;
    logic [63:0] tickcount64;

    modport master (
        output user_sw1_n,
        output user_sw2_n,
        input  rst_sys,
        input  rst_cfg_reload,
        input  led_pwronblink,
        input  tickcount64
    );

    modport slave (
        input  user_sw1_n,
        input  user_sw2_n,
        output rst_sys,
        output rst_cfg_reload,
        output led_pwronblink,
        output tickcount64
    );
endinterface

// File: rtl/pcileech_rstbtn_ctl.sv
// Board reset/button controller: syncs and debounces two push-buttons, stretches the system
// reset, raises a config-reload request on a long sw2 press and drives the power-on blink LED term.
module pcileech_rstbtn_ctl #(
    parameter int PARAM_DEBOUNCE_CYCLES   = 1000000,
    parameter int PARAM_PWRON_RST_CYCLES  = 64,
    parameter int PARAM_CFG_RELOAD_CYCLES = 500000000,
    parameter int PARAM_BLINK_BIT         = 24,
    parameter int PARAM_BLINK_LIMIT_BIT   = 27
) (
    input  logic                       clk,
    input  logic                       rst,
    pcileech_rstbtn_ctl_if.slave       btn_if
);

    localparam int DEB_W  = $clog2(PARAM_DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(PARAM_CFG_RELOAD_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(PARAM_DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(PARAM_CFG_RELOAD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(PARAM_CFG_RELOAD_CYCLES);
    localparam logic [63:0]       PWRON_LAST = 64'(PARAM_PWRON_RST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_PWRON  = 2'd0,
        S_RUN    = 2'd1,
        S_HOLD   = 2'd2,
        S_RELOAD = 2'd3
    } state_t;

    logic [1:0] btn_n;
    logic [1:0] pressed;
    logic       sw1_pressed;
    logic       sw2_pressed;

    assign btn_n       = {btn_if.user_sw2_n, btn_if.user_sw1_n};
    assign sw1_pressed = pressed[0];
    assign sw2_pressed = pressed[1];

    // Per button: 2-flop synchroniser, then a stability counter that must see
    // PARAM_DEBOUNCE_CYCLES consecutive differing samples before the state flips.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             pressed_reg;
            logic [DEB_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg   <= 1'b1;
                    sync2_reg   <= 1'b1;
                    pressed_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    sync1_reg <= btn_n[gi];
                    sync2_reg <= sync1_reg;
                    if (~sync2_reg == pressed_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        pressed_reg <= ~pressed_reg;
                        cnt_reg     <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DEB_W'(1);
                    end
                end
            end

            assign pressed[gi] = pressed_reg;
        end
    endgenerate

    logic [63:0] tick_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_reg <= '0;
        end else if (sw2_pressed) begin
            tick_reg <= '0;
        end else if (tick_reg != '1) begin
            tick_reg <= tick_reg + 64'd1;
        end
    end

    state_t              state_reg;
    state_t              state_next;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [HOLD_W-1:0]   hold_cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_PWRON;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // hold_cnt only advances inside S_HOLD, so it is zero on the first HOLD cycle.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = '0;
        case (state_reg)
            S_PWRON: begin
                if (sw2_pressed) begin
                    state_next = S_HOLD;
                end else if (tick_reg >= PWRON_LAST) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (sw2_pressed) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                hold_cnt_next = (hold_cnt_reg == HOLD_LIMIT) ? hold_cnt_reg
                                                             : hold_cnt_reg + HOLD_W'(1);
                // Release is checked first so it wins over reaching the reload limit.
                if (!sw2_pressed) begin
                    state_next = S_PWRON;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = S_RELOAD;
                end
            end
            S_RELOAD: begin
                if (!sw2_pressed) begin
                    state_next = S_PWRON;
                end
            end
            default: begin
                state_next = S_PWRON;
            end
        endcase
    end

    logic rst_sys_reg;
    logic cfg_reload_reg;
    logic led_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sys_reg    <= 1'b1;
            cfg_reload_reg <= 1'b0;
            led_reg        <= 1'b0;
        end else begin
            rst_sys_reg    <= (state_next != S_RUN);
            cfg_reload_reg <= (state_next == S_RELOAD);
            led_reg        <= sw1_pressed ^ (tick_reg[PARAM_BLINK_BIT] &
                                             (tick_reg[63:PARAM_BLINK_LIMIT_BIT] == '0));
        end
    end

    assign btn_if.rst_sys        = rst_sys_reg;
    assign btn_if.rst_cfg_reload = cfg_reload_reg;
    assign btn_if.led_pwronblink = led_reg;
    assign btn_if.tickcount64    = tick_reg;

endmodule
